lcd_write_arbiter: RTL
======================

# lcd_write_arbiter

Shares the single write-only HD44780-style LCD bus between two requesters and sequences every bus write with correct setup / enable / hold / busy-wait timing. Sits between the producers (e.g. a command engine and a text streamer) and the LCD pins driven by `lcd_display`-style logic. Each requester hands over one byte at a time via valid/ready. The arbiter owns all `enable`/`rs`/`rw`/`data` pin timing.

## Interface
- `SETUP_CYC`, 2: cycles `rs`/`data` are stable before `lcd_e` rises (≥1).
- `EN_CYC`, 4: cycles `lcd_e` is high (≥1).
- `HOLD_CYC`, 2: cycles `rs`/`data` are held after `lcd_e` falls (≥1).
- `WAIT_CYC`, 40: busy-wait after a normal write (≥1).
- `WAIT_LONG_CYC`, 1600: busy-wait after clear/home commands (≥ `WAIT_CYC`).
- `clk` in 1: single clock; all logic is posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a byte.
- `req0_rs` in 1: 0 = command, 1 = data.
- `req0_data` in 8: byte.
- `req0_ready` out 1: byte accepted on this cycle when `valid` is also high.
- `req1_valid`, `req1_rs`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `lcd_e` out 1: LCD enable strobe.
- `lcd_rs` out 1: LCD register select.
- `lcd_rw` out 1: LCD read/write; tied 0 (write-only).
- `lcd_data` out 8: LCD data bus.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE → SETUP → ENABLE → HOLD → WAIT → IDLE. A single down-counter is loaded on every state entry.
- IDLE, grant selection:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by the round-robin pointer `rr` is granted.
  - `reqN_ready = (state==IDLE) & grantN`. Ready may depend combinationally on valid.
  - On a handshake, the byte and `rs` are captured, `rr` moves to the other requester, and the FSM enters SETUP.
- Captured `rs`/`data` drive `lcd_rs`/`lcd_data` from SETUP through HOLD. They stay unchanged in WAIT and IDLE; the last value is retained.
- `lcd_e` is high only in ENABLE.
- Wait length:
  - `WAIT_LONG_CYC` when `rs==0` and `data[7:2]==0` and `data!=0`, i.e. clear `0x01` or home `0x02`/`0x03`.
  - `WAIT_CYC` otherwise.
- Never both readies high in the same cycle.
- Neither ready is high outside IDLE.

## Timing
- Reset values: `lcd_e=0`, `lcd_rs=0`, `lcd_rw=0`, `lcd_data=0x00`, `busy=0`, both readies 0 until the first IDLE cycle evaluates, `rr`=requester 0, state IDLE (or INIT, see Configuration).
- Accept at edge k. The outputs then follow this schedule:
  - `lcd_data`/`lcd_rs` are valid from k+1.
  - `lcd_e` is high during cycles k+1+`SETUP_CYC` … k+`SETUP_CYC`+`EN_CYC`.
  - The hold window follows; WAIT then runs its length.
  - The next accept is possible at edge k+`SETUP_CYC`+`EN_CYC`+`HOLD_CYC`+wait+1 at the earliest.
- Throughput is one byte per (S+E+H+W+1) cycles.
- Reset asserted mid-transfer: at the next edge, `lcd_e`=0 and state is IDLE (or INIT). The in-flight byte is dropped and not re-issued.
- A requester deasserting `valid` without a handshake is legal. No grant is latched in IDLE.

## Configuration
- `LCD_ARB_INIT_EN` defined:
  - After reset, the FSM enters INIT and issues the fixed ROM sequence 0x38, 0x0C, 0x06, 0x01 (all `rs=0`) through the normal SETUP…WAIT path.
  - Both readies are held 0 and `busy=1` until the 0x01 wait completes.
- Not defined: no INIT state; the FSM is idle straight from reset.

## Structure
- Package `lcd_pkg` holds:
  - the state enum;
  - command constants `LCD_CMD_CLEAR=8'h01`, `LCD_CMD_HOME=8'h02`;
  - the init ROM length and contents.
- Sub-module `lcd_cycle_timer`: loadable down-counter with a `done` pulse. It is shared across all timed states.

## Test plan
- **Single write.** Only req0 valid, `rs=1`, data 0x41, default params.
  - req0_ready pulses once; `lcd_data=0x41`, `lcd_rs=1`.
  - `lcd_e` is high for exactly 4 cycles, starting 2 cycles after the first data cycle.
  - `busy` lasts 48 cycles; `lcd_rw` stays 0.
- **Contention.** Both valid continuously, req0 data 0x10, req1 data 0x20.
  - The bus sees 0x10, 0x20, 0x10, 0x20 (alternating).
  - Readies are never simultaneous.
- **Long wait.** req1 sends `rs=0`, data 0x01, then 0x0C.
  - Wait after 0x01 is 1600 cycles; wait after 0x0C is 40 cycles.
  - A `rs=1`, data 0x01 byte uses 40 cycles.
- **Reset mid-operation.** Assert `rst_n=0` during ENABLE.
  - Next edge: `lcd_e=0`, `busy=0`.
  - After release, the next request is accepted normally; `rr` is back at requester 0.
- **Init sequence.** With `LCD_ARB_INIT_EN` defined and req0 held valid from reset:
  - The bus shows 0x38, 0x0C, 0x06, 0x01 first.
  - The first req0_ready comes only after the 0x01 long wait completes.

Source files
------------

// File: rtl/lcd_write_arbiter_pkg.sv
// Shared types and constants for the two-requester HD44780 write arbiter.
// The ST_INIT state and the init ROM are used only when LCD_ARB_INIT_EN is defined.
package lcd_pkg;

    typedef enum logic [2:0] {
`ifdef LCD_ARB_INIT_EN
        ST_INIT,
`endif
        ST_IDLE,
        ST_SETUP,
        ST_ENABLE,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    localparam int INIT_LEN   = 4;
    localparam int INIT_IDX_W = $clog2(INIT_LEN);

    // Power-up sequence: 8-bit/2-line, display on, entry mode, clear.
    function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
        logic [7:0] value;
        case (idx)
            2'd0:    value = 8'h38;
            2'd1:    value = 8'h0C;
            2'd2:    value = 8'h06;
            default: value = LCD_CMD_CLEAR;
        endcase
        return value;
    endfunction

    // Clear and return-home (0x01..0x03 as commands) need the long busy-wait.
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME ||
                       data == (LCD_CMD_HOME | LCD_CMD_CLEAR));
    endfunction

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Requester handshakes and LCD pins for lcd_write_arbiter.
// The slave modport is the arbiter's view; master is the producer/pin side.
interface lcd_write_arbiter_if;

    logic       req0_valid;
    logic       req0_rs;
    logic [7:0] req0_data;
    logic       req0_ready;

    logic       req1_valid;
    logic       req1_rs;
    logic [7:0] req1_data;
    logic       req1_ready;

    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       busy;

    modport slave (
        input  req0_valid, req0_rs, req0_data,
        output req0_ready,
        input  req1_valid, req1_rs, req1_data,
        output req1_ready,
        output lcd_e, lcd_rs, lcd_rw, lcd_data, busy
    );

    modport master (
        output req0_valid, req0_rs, req0_data,
        input  req0_ready,
        output req1_valid, req1_rs, req1_data,
        input  req1_ready,
        input  lcd_e, lcd_rs, lcd_rw, lcd_data, busy
    );

endinterface

// File: rtl/lcd_write_arbiter_timer.sv
// Loadable down-counter shared by every timed arbiter state.
// Loading N-1 yields done_o on the Nth cycle after the load edge.
module lcd_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] loadVal_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic         run_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= loadVal_i;
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sequencing HD44780 writes (setup/enable/hold/busy-wait).
// Define LCD_ARB_INIT_EN to issue the power-up command ROM after reset.
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC     = 2,
    parameter int EN_CYC        = 4,
    parameter int HOLD_CYC      = 2,
    parameter int WAIT_CYC      = 40,
    parameter int WAIT_LONG_CYC = 1600
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd_write_arbiter_if.slave  bus
);

    localparam int MAX_A = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_B = (HOLD_CYC > WAIT_LONG_CYC) ? HOLD_CYC : WAIT_LONG_CYC;
    localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXC) + 1;

    lcd_state_e  state_q;
    logic        rr_q;
    logic        capRs_q;
    logic [7:0]  capData_q;
    logic        lcdE_q;
    logic        busy_q;
`ifdef LCD_ARB_INIT_EN
    logic [INIT_IDX_W-1:0] initIdx_q;
    logic                  initPend_q;
`endif

    logic          grant0;
    logic          grant1;
    logic          ready0;
    logic          ready1;
    logic          tmrLoad;
    logic [CW-1:0] tmrVal;
    logic [CW-1:0] waitVal;
    logic          tmrDone;

    // Round-robin pointer only matters when both requesters are valid.
    always_comb begin
        grant0  = bus.req0_valid && (!bus.req1_valid || !rr_q);
        grant1  = bus.req1_valid && (!bus.req0_valid ||  rr_q);
        ready0  = (state_q == ST_IDLE) && grant0;
        ready1  = (state_q == ST_IDLE) && grant1;
        waitVal = needs_long_wait(capRs_q, capData_q) ? CW'(WAIT_LONG_CYC - 1)
                                                      : CW'(WAIT_CYC - 1);
        tmrLoad = 1'b0;
        tmrVal  = '0;
        case (state_q)
`ifdef LCD_ARB_INIT_EN
            ST_INIT: begin
                tmrLoad = 1'b1;
                tmrVal  = CW'(SETUP_CYC - 1);
            end
`endif
            ST_IDLE: begin
                tmrLoad = ready0 || ready1;
                tmrVal  = CW'(SETUP_CYC - 1);
            end
            ST_SETUP: begin
                tmrLoad = tmrDone;
                tmrVal  = CW'(EN_CYC - 1);
            end
            ST_ENABLE: begin
                tmrLoad = tmrDone;
                tmrVal  = CW'(HOLD_CYC - 1);
            end
            ST_HOLD: begin
                tmrLoad = tmrDone;
                tmrVal  = waitVal;
            end
            default: begin
                tmrLoad = 1'b0;
                tmrVal  = '0;
            end
        endcase
    end

    lcd_cycle_timer #(.W(CW)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmrLoad),
        .loadVal_i (tmrVal),
        .done_o    (tmrDone)
    );

    // Pin registers are updated on state transitions so they stay glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
`ifdef LCD_ARB_INIT_EN
            state_q    <= ST_INIT;
            initIdx_q  <= '0;
            initPend_q <= 1'b1;
`else
            state_q    <= ST_IDLE;
`endif
            rr_q      <= 1'b0;
            capRs_q   <= 1'b0;
            capData_q <= 8'h00;
            lcdE_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
`ifdef LCD_ARB_INIT_EN
                ST_INIT: begin
                    capRs_q   <= 1'b0;
                    capData_q <= init_rom(initIdx_q);
                    initIdx_q <= initIdx_q + 1'b1;
                    if (initIdx_q == INIT_IDX_W'(INIT_LEN - 1)) begin
                        initPend_q <= 1'b0;
                    end
                    busy_q  <= 1'b1;
                    state_q <= ST_SETUP;
                end
`endif
                ST_IDLE: begin
                    if (ready0) begin
                        capRs_q   <= bus.req0_rs;
                        capData_q <= bus.req0_data;
                        rr_q      <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SETUP;
                    end else if (ready1) begin
                        capRs_q   <= bus.req1_rs;
                        capData_q <= bus.req1_data;
                        rr_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmrDone) begin
                        lcdE_q  <= 1'b1;
                        state_q <= ST_ENABLE;
                    end
                end
                ST_ENABLE: begin
                    if (tmrDone) begin
                        lcdE_q  <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmrDone) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tmrDone) begin
`ifdef LCD_ARB_INIT_EN
                        if (initPend_q) begin
                            state_q <= ST_INIT;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
`else
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    lcdE_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.lcd_e      = lcdE_q;
    assign bus.lcd_rs     = capRs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_data   = capData_q;
    assign bus.busy       = busy_q;

endmodule
